// File: rtl/clut_write_scheduler_pkg.sv
// CLUT write scheduler shared types.
// State encoding, default CLUT widths and a saturating counter helper.
package clut_write_scheduler_pkg;

  localparam int CIDXW_DEF = 4;
  localparam int COLRW_DEF = 12;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  function automatic logic [15:0] sat_add16(
    input logic [15:0] a,
    input logic        inc
  );
    return (inc && a != 16'hFFFF) ? a + 16'd1 : a;
  endfunction

endpackage

// File: rtl/clut_write_scheduler_if.sv
// Requester bundle plus CLUT write port.
// master: palette producers; slave: the scheduler.
interface clut_write_scheduler_if
  import clut_write_scheduler_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int CIDXW = CIDXW_DEF,
  parameter int COLRW = COLRW_DEF
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*CIDXW-1:0] req_cidx;
  logic [NREQ*COLRW-1:0] req_colr;
  logic [NREQ-1:0]       req_ready;
  logic                  clut_we;
  logic [CIDXW-1:0]      clut_cidx;
  logic [COLRW-1:0]      clut_colr;

  modport master (
    output req_valid, req_last,
    output req_cidx, req_colr,
    input  req_ready,
    input  clut_we, clut_cidx, clut_colr
  );

  modport slave (
    input  req_valid, req_last,
    input  req_cidx, req_colr,
    output req_ready,
    output clut_we, clut_cidx, clut_colr
  );

endinterface

// File: rtl/clut_write_scheduler_rr_arbiter_nreq.sv
// Combinational round-robin search starting at ptr, wrapping mod NREQ.
// Ports: req, ptr in; winner, any_valid out.
module rr_arbiter_nreq #(
  parameter  int NREQ = 3,
  localparam int OWNW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OWNW-1:0] ptr,
  output logic [OWNW-1:0] winner,
  output logic            any_valid
);

  logic            found;
  logic [OWNW-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = OWNW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/clut_write_scheduler.sv
// Round-robin, burst-atomic CLUT write scheduler; writes only in blanking.
// Ports: clk_pix, rst_pix_n, de, frame, bus (slave), busy, owner, frame_writes.
module clut_write_scheduler
  import clut_write_scheduler_pkg::*;
#(
  parameter  int NREQ      = 3,
  parameter  int CIDXW     = CIDXW_DEF,
  parameter  int COLRW     = COLRW_DEF,
  parameter  int MAX_BURST = 16,
  localparam int OWNW      = $clog2(NREQ)
) (
  input  logic            clk_pix,
  input  logic            rst_pix_n,
  input  logic            de,
  input  logic            frame,
  clut_write_scheduler_if.slave bus,
  output logic            busy,
  output logic [OWNW-1:0] owner,
  output logic [15:0]     frame_writes
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  logic [1:0]       rst_sync;
  logic             rst_n;
  state_e           state, st_nxt;
  logic [OWNW-1:0]  rr_ptr, win, ptr_nxt;
  logic             any_v;
  logic [BCW-1:0]   bcnt;
  logic [NREQ-1:0]  ready;
  logic             xfer, done, grab;
  logic             sel_valid, sel_last;
  logic [CIDXW-1:0] sel_cidx;
  logic [COLRW-1:0] sel_colr;
  logic             we_q;
  logic [CIDXW-1:0] cidx_q;
  logic [COLRW-1:0] colr_q;
  logic [15:0]      wcnt;

  // async assert, release two edges later
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  rr_arbiter_nreq #(.NREQ(NREQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .winner    (win),
    .any_valid (any_v)
  );

  always_comb begin
    ready     = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_cidx  = '0;
    sel_colr  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == OWNW'(i)) begin
        ready[i]  = (state == ST_BURST) && !de;
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_cidx  = bus.req_cidx[i*CIDXW +: CIDXW];
        sel_colr  = bus.req_colr[i*COLRW +: COLRW];
      end
    end
  end

  assign xfer = sel_valid && (|ready);
  assign done = xfer &&
    (sel_last || bcnt == BCW'(MAX_BURST - 1));
  assign ptr_nxt = (owner == OWNW'(NREQ - 1))
    ? '0 : owner + 1'b1;

  always_comb begin
    st_nxt = state;
    grab   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!de && any_v) begin
          st_nxt = ST_BURST;
          grab   = 1'b1;
        end
      end
      ST_BURST: begin
        if (done) st_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= st_nxt;
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      owner        <= '0;
      rr_ptr       <= '0;
      bcnt         <= '0;
      we_q         <= 1'b0;
      cidx_q       <= '0;
      colr_q       <= '0;
      wcnt         <= '0;
      frame_writes <= '0;
    end else begin
      we_q <= xfer;
      if (xfer) begin
        cidx_q <= sel_cidx;
        colr_q <= sel_colr;
      end
      if (grab) begin
        owner <= win;
        bcnt  <= '0;
      end else if (xfer) begin
        bcnt <= bcnt + 1'b1;
      end
      if (done) rr_ptr <= ptr_nxt;
      // a write landing on the frame pulse closes out the old frame
      if (frame) begin
        frame_writes <= sat_add16(wcnt, we_q);
        wcnt         <= '0;
      end else begin
        wcnt <= sat_add16(wcnt, we_q);
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.clut_we   = we_q;
  assign bus.clut_cidx = cidx_q;
  assign bus.clut_colr = colr_q;
  assign busy          = (state == ST_BURST);

endmodule

// File: doc/clut_write_scheduler.md
Name: clut_write_scheduler

Overview:
- Shares the single CLUT write port (we / cidx_write / colr_in) between NREQ palette requesters, e.g. fade engine, palette loader and debug poker.
- Writes are issued only while de is low (blanking), so the visible image never tears mid-line.
- Grants are round-robin and burst-atomic: one requester's palette burst is never interleaved with another's.
- Sits between the palette producers and clut_simple in the pixel clock domain.

Parameters:
- NREQ, 3, number of requesters (2..8)
- CIDXW, 4, colour index width
- COLRW, 12, colour word width (3 x 4-bit channels)
- MAX_BURST, 16, maximum transfers per grant (1..2^CIDXW)
- OWNW, $clog2(NREQ), owner index width (localparam)

Ports:
- clk_pix  in  1  pixel clock
- rst_pix_n  in  1  asynchronous active-low reset
- de  in  1  display enable; a write window is open when de==0
- frame  in  1  one-cycle start-of-frame pulse
- req_valid  in  NREQ  per-requester write valid
- req_last  in  NREQ  final word of the requester's burst
- req_cidx  in  NREQ*CIDXW  packed indices, requester i at [i*CIDXW +: CIDXW]
- req_colr  in  NREQ*COLRW  packed colours, same packing
- req_ready  out  NREQ  per-requester accept; at most one bit high
- clut_we  out  1  CLUT write enable
- clut_cidx  out  CIDXW  CLUT write index
- clut_colr  out  COLRW  CLUT write colour
- busy  out  1  a grant is held (state BURST)
- owner  out  OWNW  current or last grant holder
- frame_writes  out  16  number of CLUT writes during the previous frame

Behaviour:
- Reset (async assert, sync deassert in the top level):
  - state=IDLE; rr_ptr=0, owner=0; burst count=0.
  - clut_we=0, clut_cidx=0, clut_colr=0, frame_writes=0, frame counter=0.
- FSM states: IDLE, BURST.
- IDLE -> BURST:
  - Triggered when de==0 and any req_valid is high.
  - The winner is the first valid requester searching from rr_ptr upward, mod NREQ.
  - On the next edge: owner <= winner, burst count <= 0, state <= BURST.
  - The arbitration cycle never asserts ready.
- req_ready[i] = (state==BURST) && (owner==i) && !de.
  - Combinational from registered state and the de input.
  - All other bits are 0.
- Transfer: req_valid[owner] && req_ready[owner].
  - On the next edge: clut_we<=1, and clut_cidx/clut_colr <= the owner's slice.
  - Latency is exactly 1 cycle.
  - clut_we<=0 on every other edge; cidx/colr hold their last value.
- BURST -> IDLE:
  - Occurs on a transfer with req_last[owner]=1, or on the transfer that makes burst count reach MAX_BURST.
  - On exit, rr_ptr <= (owner+1) mod NREQ.
- de rising mid-burst: ready drops immediately. State and owner are held, and no other requester can win. Ready resumes when de falls.
- Owner valid low in BURST: the grant is held with no transfer. Requesters must complete bursts with last.
- Back-to-back bursts:
  - At least 1 idle cycle (the arbitration cycle) separates the last transfer of one burst and the first of the next.
  - Maximum throughput within a burst is 1 write per cycle.
- Valid/data changes while ready is low are ignored. Data is sampled only on a transfer.
- Write counter:
  - Increments on each clut_we; saturates at 16'hFFFF.
  - On frame: frame_writes <= counter (plus 1 if clut_we is high that cycle); counter <= 0.
  - A write coinciding with frame is counted in the closing frame.
- busy = (state==BURST). owner is registered.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, BURST=1'b1) and the default CIDXW/COLRW shared with clut_simple.
- One natural sub-module: rr_arbiter_nreq. It is combinational and does the round-robin search from rr_ptr, returning winner index and any_valid. It can be reused by other shared-resource schedulers.

Test Plan:
- Single requester 1: de=0, 4-word burst (cidx 0..3, colr 12'hF00..F03, last on the 4th) -> req_ready[1] rises 1 cycle after valid; clut_we pulses 4 consecutive cycles, each 1 cycle after the transfer; busy falls after the 4th; rr_ptr=2.
- All 3 requesting continuously with 2-word bursts, rr_ptr=0 -> grant order 0,1,2,0; 1 gap cycle between bursts; req_ready is never multi-hot.
- de rises after 2 of 5 words of requester 0 -> ready low and clut_we stops while de=1; requester 2 valid is not granted; words 3..5 complete after de falls; cidx sequence intact.
- MAX_BURST=16 and requester 1 streams 20 words with no last -> exactly 16 writes, then IDLE, then re-arbitration; with only requester 1 valid it regains the grant and writes the remaining 4.
- frame pulses with 7 writes in a frame, the 7th coincident with frame -> frame_writes=7; the next frame's count starts at 0.
- Assert rst_pix_n low mid-burst (asynchronous, between edges) -> clut_we, req_ready and busy drop to 0 immediately; after release, state IDLE, rr_ptr=0, frame_writes=0.
